// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle arithmetic/logic,
// bit-serial shifts/rotates and shift-add unsigned multiply with status flags.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_NOT = 4'd7,
        OP_ASR = 4'd8, OP_ROL = 4'd9, OP_MUL = 4'd10, OP_CMP = 4'd11
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;

    logic [WIDTH:0]     sum, diff, mac;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   sh_val;
    logic               sh_c;
    logic [SHW-1:0]     amt;
    logic               ov_add, ov_sub;

    // Output registers are loaded only through the commit path, so they keep
    // the previous op's values while a new op is still iterating in EXEC.
    logic             commit;
    logic [WIDTH-1:0] nxt_res, nxt_hi;
    logic             nxt_z, nxt_n, nxt_c, nxt_v, nxt_err;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        err_d    = err_q;

        commit  = 1'b0;
        nxt_res = '0;
        nxt_hi  = '0;
        nxt_z   = 1'b0;
        nxt_n   = 1'b0;
        nxt_c   = 1'b0;
        nxt_v   = 1'b0;
        nxt_err = 1'b0;

        amt    = B[SHW-1:0];
        sum    = {1'b0, A} + {1'b0, B};
        diff   = {1'b0, A} - {1'b0, B};
        ov_add = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        ov_sub = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

        // One multiply step: conditionally add A to the high half, then shift
        // the whole {hi, lo} pair right, consuming one multiplier bit from lo.
        mac  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        prod = {mac, lo_q[WIDTH-1:1]};

        sh_val = lo_q;
        sh_c   = 1'b0;
        case (op_q)
            OP_SHL: begin sh_val = {lo_q[WIDTH-2:0], 1'b0};        sh_c = lo_q[WIDTH-1]; end
            OP_SHR: begin sh_val = {1'b0, lo_q[WIDTH-1:1]};        sh_c = lo_q[0];       end
            OP_ASR: begin sh_val = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]}; sh_c = lo_q[0];     end
            default: begin sh_val = {lo_q[WIDTH-2:0], lo_q[WIDTH-1]}; sh_c = lo_q[WIDTH-1]; end
        endcase

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    op_d    = op;
                    lo_d    = A;
                    hi_d    = '0;
                    state_d = DONE;
                    commit  = 1'b1;
                    case (op)
                        OP_ADD: begin nxt_res = sum[WIDTH-1:0];  nxt_c = sum[WIDTH];  nxt_v = ov_add; end
                        OP_SUB: begin nxt_res = diff[WIDTH-1:0]; nxt_c = diff[WIDTH]; nxt_v = ov_sub; end
                        OP_CMP: begin nxt_res = A;               nxt_c = diff[WIDTH]; nxt_v = ov_sub; end
                        OP_AND: nxt_res = A & B;
                        OP_OR:  nxt_res = A | B;
                        OP_XOR: nxt_res = A ^ B;
                        OP_NOT: nxt_res = ~A;
                        OP_SHL, OP_SHR, OP_ASR, OP_ROL: begin
                            nxt_res = A;
                            if (amt != '0) begin
                                state_d = EXEC;
                                commit  = 1'b0;
                                cnt_d   = CW'(amt);
                            end
                        end
                        OP_MUL: begin
                            lo_d    = B;
                            state_d = EXEC;
                            commit  = 1'b0;
                            cnt_d   = CW'(WIDTH);
                        end
                        default: nxt_err = 1'b1;
                    endcase
                    nxt_z = (nxt_res == '0);
                    nxt_n = nxt_res[WIDTH-1];
                    if (op == OP_CMP) begin
                        nxt_z = (diff[WIDTH-1:0] == '0);
                        nxt_n = diff[WIDTH-1];
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == OP_MUL) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    lo_d = sh_val;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    commit  = 1'b1;
                    if (op_q == OP_MUL) begin
                        nxt_res = prod[WIDTH-1:0];
                        nxt_hi  = prod[2*WIDTH-1:WIDTH];
                        nxt_z   = (prod == '0);
                        nxt_n   = prod[2*WIDTH-1];
                    end else begin
                        nxt_res = sh_val;
                        nxt_z   = (sh_val == '0);
                        nxt_n   = sh_val[WIDTH-1];
                        nxt_c   = sh_c;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            res_d    = nxt_res;
            res_hi_d = nxt_hi;
            z_d      = nxt_z;
            n_d      = nxt_n;
            c_d      = nxt_c;
            v_d      = nxt_v;
            err_d    = nxt_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic reference
// model, plus the directed handshake, backpressure and abort scenarios.
module tb_seq_alu;

    localparam int W = 8;
    localparam int M = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, result, result_hi;
    logic [3:0]   op;
    logic         flag_z, flag_n, flag_c, flag_v, err;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int lo, hi, z, n, c, v, err, lat;
    } exp_t;

    function automatic int to_signed(int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    function automatic exp_t model(int a, int b, int o);
        exp_t e;
        int   s, sv, r, p;
        e = '{default: 0};
        e.lat = 1;
        s  = b & (W - 1);
        r  = 0;
        sv = 0;
        case (o)
            0: begin
                r = a + b; e.lo = r & M; e.c = (r > M) ? 1 : 0;
                sv = to_signed(a) + to_signed(b);
                e.v = (sv > (M >> 1) || sv < -(1 << (W - 1))) ? 1 : 0;
            end
            1, 11: begin
                r = a - b; e.lo = (o == 1) ? (r & M) : a; e.c = (a < b) ? 1 : 0;
                sv = to_signed(a) - to_signed(b);
                e.v = (sv > (M >> 1) || sv < -(1 << (W - 1))) ? 1 : 0;
            end
            2: e.lo = a & b;
            3: e.lo = a | b;
            4: e.lo = a ^ b;
            7: e.lo = (~a) & M;
            5: begin e.lo = (a << s) & M;  e.c = (s != 0) ? (a >> (W - s)) & 1 : 0; end
            6: begin e.lo = a >> s;        e.c = (s != 0) ? (a >> (s - 1)) & 1 : 0; end
            8: begin e.lo = (to_signed(a) >>> s) & M; e.c = (s != 0) ? (a >> (s - 1)) & 1 : 0; end
            9: begin e.lo = ((a << s) | (a >> (W - s))) & M; e.c = (s != 0) ? e.lo & 1 : 0; end
            10: begin
                p = a * b; e.lo = p & M; e.hi = p >> W;
                e.lat = 1 + W;
            end
            default: e.err = 1;
        endcase
        if (o inside {5, 6, 8, 9} && s != 0) e.lat = 1 + s;
        if (o == 10) begin
            e.z = (e.lo == 0 && e.hi == 0) ? 1 : 0;
            e.n = (e.hi >> (W - 1)) & 1;
        end else if (o == 11) begin
            e.z = ((r & M) == 0) ? 1 : 0;
            e.n = ((r & M) >> (W - 1)) & 1;
        end else begin
            e.z = (e.lo == 0) ? 1 : 0;
            e.n = (e.lo >> (W - 1)) & 1;
        end
        return e;
    endfunction

    function automatic logic [2*W+4:0] pack_out();
        return {result_hi, result, flag_z, flag_n, flag_c, flag_v, err};
    endfunction

    function automatic logic [2*W+4:0] pack_exp(exp_t e);
        return {W'(e.hi), W'(e.lo), e.z[0], e.n[0], e.c[0], e.v[0], e.err[0]};
    endfunction

    // Issues one op, checks latency and outputs, holds out_ready low for
    // 'hold' cycles (optionally poking in_valid), then completes the handshake.
    task automatic issue(input int a, input int b, input int o, input int hold,
                         input bit poke, output exp_t e);
        int g, lat;
        e = model(a, b, o);
        g = 0;
        while (!in_ready && g < 20) begin @(posedge clk); #1; g++; end
        chk("in_ready_idle", in_ready, 1);
        A = W'(a); B = W'(b); op = 4'(o); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = W'($urandom); B = W'($urandom); op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, e.lat);
        chk("result", result, e.lo);
        chk("result_hi", result_hi, e.hi);
        chk("flags_zncv_err", {flag_z, flag_n, flag_c, flag_v, err}, pack_exp(e) & 5'h1f);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_outputs", pack_out(), pack_exp(e));
            in_valid = (poke && i == 1);
            op = 4'd0; A = 8'h11; B = 8'h22;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("outputs_kept", pack_out(), pack_exp(e));
    endtask

    initial begin
        exp_t e;
        int   seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; op = '0;
        #12;
        chk("rst_outputs", pack_out(), '0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        issue('hFF, 'h01, 0, 0, 0, e);  chk("tp_add", pack_out(), {8'h00, 8'h00, 5'b10100});
        issue('h80, 'h01, 1, 1, 0, e);  chk("tp_sub", pack_out(), {8'h00, 8'h7F, 5'b00010});
        issue('h05, 'h07, 11, 0, 0, e); chk("tp_cmp", pack_out(), {8'h00, 8'h05, 5'b01100});
        issue('h90, 'h02, 8, 0, 0, e);  chk("tp_asr", pack_out(), {8'h00, 8'hE4, 5'b01000});
        issue('h81, 'h01, 9, 0, 0, e);  chk("tp_rol", pack_out(), {8'h00, 8'h03, 5'b00100});
        issue('h5A, 'h00, 5, 0, 0, e);  chk("tp_shl0", pack_out(), {8'h00, 8'h5A, 5'b00000});
        issue('hFF, 'hFF, 10, 0, 0, e); chk("tp_mul", pack_out(), {8'hFE, 8'h01, 5'b01000});
        issue('h00, 'h37, 10, 0, 0, e); chk("tp_mul0", pack_out(), {8'h00, 8'h00, 5'b10000});
        issue('h12, 'h34, 4, 5, 1, e);
        @(posedge clk); #1;
        chk("poke_ignored", out_valid, 0);
        issue('h3C, 'h5A, 13, 0, 0, e); chk("tp_illegal", pack_out(), {8'h00, 8'h00, 5'b10001});

        // Abort a multiply part-way through with an asynchronous reset.
        issue('hC3, 'h0F, 2, 0, 0, e);
        A = 8'hFF; B = 8'h03; op = 4'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("abort_outputs", pack_out(), '0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (14) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("abort_no_valid", seen, 0);

        for (int t = 0; t < 150; t++) begin
            issue(int'($urandom_range(0, M)), int'($urandom_range(0, M)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 0, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the mini datapath with valid/ready handshakes on both sides. It extends the combinational 8-function ALU with registered results, Z/N/C/V status flags, and variable-amount shifts and rotates. It also adds iterative shift-add multiplication with a double-width product. It sits between the register-file read stage and write-back. Operands are captured on acceptance and the result is held until the consumer takes it.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/opcode offer
- in_ready  out  1  block can accept; high only in IDLE
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; for shifts/rotates only B[SHW-1:0] is used as the amount
- op  in  4  opcode (see Operation)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result, or low half of product
- result_hi  out  WIDTH  high half of product; 0 for non-MUL ops
- flag_z, flag_n, flag_c, flag_v  out  1 each  zero, negative, carry/borrow, signed overflow
- err  out  1  illegal opcode in the delivered result

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SHL (logical)
  - 0110 SHR (logical)
  - 0111 NOT A
  - 1000 ASR (arithmetic right)
  - 1001 ROL
  - 1010 MUL (unsigned, 2·WIDTH-bit product)
  - 1011 CMP (A−B; flags only, result = A)
  - 1100–1111 illegal
- FSM states are IDLE, EXEC and DONE. Reset state is IDLE.
- IDLE:
  - on in_valid & in_ready, capture A, B, op.
  - Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, CMP, illegal) compute and go to DONE.
  - SHL, SHR, ASR and ROL with amount 0 go directly to DONE with result = A and C = 0.
  - Otherwise load the counter (shift amount, or WIDTH for MUL) and go to EXEC.
- EXEC:
  - Shifts/rotates perform one bit position per cycle. C takes the last bit shifted or rotated out.
  - MUL performs one shift-add step per cycle over WIDTH cycles.
  - When the counter reaches 0, go to DONE.
- DONE:
  - out_valid = 1; result, result_hi, flags and err are held stable.
  - On out_ready, go to IDLE.
- Flags are computed from the final result:
  - Z = (result == 0); for MUL, Z = ({result_hi,result} == 0).
  - N = MSB of result; for MUL, N = MSB of result_hi.
  - ADD: C = carry out of bit WIDTH-1. V = signed overflow.
  - SUB/CMP: C = borrow (1 iff A < B unsigned). V = signed overflow of A−B.
  - Logical ops, NOT and MUL: C = 0, V = 0.
  - Shifts/rotates: V = 0.
- Illegal opcode: result = 0, result_hi = 0, Z = 1, N = C = V = 0, err = 1. err = 0 for all legal ops.
- Operand and opcode changes after acceptance have no effect.
- No input is accepted in EXEC or DONE.

## Timing
- Reset:
  - state IDLE.
  - out_valid, result, result_hi, all flags and err = 0.
  - in_ready = 1, since it is combinational from state == IDLE.
- Latency is counted from the accepting edge k to the first edge at which out_valid = 1:
  - single-cycle ops and zero-amount shifts: out_valid at k+1.
  - shift/rotate by s > 0: out_valid at k+1+s.
  - MUL: out_valid at k+1+WIDTH.
- The output handshake completes on an edge with out_valid & out_ready.
  - out_valid drops after that edge and in_ready = 1 in the following cycle.
  - Minimum issue interval is 2 cycles.
- Outputs (result, result_hi, flags, err) keep their last value after the handshake until the next op reaches DONE.
- out_valid & !out_ready: hold indefinitely with no change to any output.
- rst asserted mid-EXEC or mid-DONE: immediate abort to IDLE, all outputs cleared, and no out_valid for the aborted op.

## Test plan
- ADD A=0xFF, B=0x01 -> result 0x00, Z=1, C=1, V=0, N=0; out_valid exactly 1 cycle after accept.
- SUB A=0x80, B=0x01 -> result 0x7F, V=1, C=0, N=0. Then CMP A=0x05, B=0x07 -> result 0x05, C=1, N=1, Z=0.
- Shifts:
  - ASR A=0x90, B=2 -> result 0xE4, C=0, N=1, out_valid at accept+3.
  - ROL A=0x81, B=1 -> result 0x03, C=1.
  - SHL with B=0 -> result = A, C=0, out_valid at accept+1.
- MUL A=0xFF, B=0xFF -> result_hi 0xFE, result 0x01, N=1, Z=0, C=V=0, out_valid at accept+9. MUL A=0x00 -> Z=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: all outputs stable, in_ready=0, and an in_valid pulse is ignored.
  - Raise out_ready: handshake, then in_ready=1 the next cycle.
- Reset and error cases:
  - Assert rst 4 cycles into a MUL: all outputs 0, in_ready=1, and no out_valid after release.
  - Illegal op 1101 -> result 0, Z=1, err=1.
